// File: rtl/axil_reg_bank_if.sv
// AXI-Lite bus bundle for the register bank: the five channels, 32-bit address and data.
// Every channel transfers on a clock edge where its valid and ready are both high; a source holds valid and its payload stable until that edge.
interface axil_reg_bank_if;
   logic [31:0] axi_awaddr;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wvalid;
   logic        axi_wready;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready;
   logic [31:0] axi_araddr;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rvalid;
   logic        axi_rready;

   modport master (
      output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
             axi_araddr, axi_arvalid, axi_rready,
      input  axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready,
             axi_rdata, axi_rresp, axi_rvalid
   );

   modport slave (
      input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
             axi_araddr, axi_arvalid, axi_rready,
      output axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready,
             axi_rdata, axi_rresp, axi_rvalid
   );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI-Lite register bank: RW control words with self-clearing pulse bits, live status words,
// sticky W1C event flags with an enable mask and a registered level interrupt.
module axil_reg_bank #(
   parameter logic [15:0]            ADDR_SEGMENT = 16'h0000,
   parameter int                     NUM_CTRL     = 8,
   parameter int                     NUM_STAT     = 4,
   parameter int                     NUM_EVT      = 8,
   parameter logic [NUM_CTRL*32-1:0] PULSE_MASK   = '0,
   parameter logic [NUM_CTRL*32-1:0] CTRL_RESET   = '0,
   parameter logic [31:0]            BLOCK_ID     = 32'h5246_0002
) (
   input  logic                     axilite_clk,
   input  logic                     axilite_rst,
   axil_reg_bank_if.slave           axi,
   output logic [NUM_CTRL*32-1:0]   ctrl_regs,
   output logic [NUM_CTRL-1:0]      ctrl_wr_pulse,
   input  logic [NUM_STAT*32-1:0]   stat_in,
   input  logic [NUM_EVT-1:0]       event_in,
   output logic [NUM_EVT-1:0]       event_pending,
   output logic                     irq
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      K_CTRL, K_STAT, K_PEND, K_EN, K_ID, K_UNMAP, K_SEG
   } kind_e;

   typedef struct packed {
      kind_e kind;
      int    idx;
   } dec_t;

   // Word offset inside the 64 KiB segment; the low two address bits never take part.
   function automatic dec_t decode(input logic [31:2] addr);
      dec_t d;
      d.idx = {24'd0, addr[9:2]};
      if (addr[31:16] != ADDR_SEGMENT)
         d.kind = K_SEG;
      else if (addr[15:10] == 6'h00)
         d.kind = (d.idx < NUM_CTRL) ? K_CTRL : K_UNMAP;
      else if (addr[15:10] == 6'h01)
         d.kind = (d.idx < NUM_STAT) ? K_STAT : K_UNMAP;
      else if (addr[15:2] == 14'h200)
         d.kind = K_PEND;
      else if (addr[15:2] == 14'h201)
         d.kind = K_EN;
      else if (addr[15:2] == 14'h3FF)
         d.kind = K_ID;
      else
         d.kind = K_UNMAP;
      return d;
   endfunction

   // Write-side holders
   logic        aw_full;
   logic [31:2] aw_addr_q;
   logic        w_full;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        bvalid_q;
   logic [1:0]  bresp_q;

   // Read-side response registers
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;

   // Register state
   logic [31:0]         ctrl_q [NUM_CTRL];
   logic [31:0]         ctrl_d [NUM_CTRL];
   logic [NUM_CTRL-1:0] pulse_q;
   logic [NUM_CTRL-1:0] pulse_d;
   logic [NUM_EVT-1:0]  pend_q;
   logic [NUM_EVT-1:0]  pend_d;
   logic [NUM_EVT-1:0]  en_q;
   logic [NUM_EVT-1:0]  en_d;
   logic                irq_q;

   logic        commit;
   dec_t        w_dec;
   dec_t        r_dec;
   logic [31:0] bmask;
   logic [31:0] evt_clr;
   logic [1:0]  wr_resp;
   logic [31:0] rd_data;
   logic [1:0]  rd_resp;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^{axi.axi_awaddr[1:0], axi.axi_araddr[1:0]};

   // A write commits only once both halves are held and the previous response has been taken.
   assign commit = aw_full & w_full & ~bvalid_q;

   always_comb begin
      w_dec   = decode(aw_addr_q);
      bmask   = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
      wr_resp = RESP_SLVERR;
      evt_clr = '0;
      en_d    = en_q;

      case (w_dec.kind)
         K_CTRL, K_PEND, K_EN: wr_resp = RESP_OKAY;
         K_SEG:                wr_resp = RESP_DECERR;
         default:              wr_resp = RESP_SLVERR;
      endcase

      // Pulse bits live for one cycle only; everything else holds unless written.
      for (int k = 0; k < NUM_CTRL; k++) begin
         ctrl_d[k]  = ctrl_q[k] & ~PULSE_MASK[32*k +: 32];
         pulse_d[k] = 1'b0;
         if (commit && (w_dec.kind == K_CTRL) && (w_dec.idx == k)) begin
            ctrl_d[k]  = (ctrl_d[k] & ~bmask) | (w_data_q & bmask);
            pulse_d[k] = 1'b1;
         end
      end

      if (commit && (w_dec.kind == K_PEND))
         evt_clr = w_data_q & bmask;
      // A new event in the clearing cycle keeps its flag set.
      pend_d = (pend_q & ~evt_clr[NUM_EVT-1:0]) | event_in;

      if (commit && (w_dec.kind == K_EN))
         en_d = (en_q & ~bmask[NUM_EVT-1:0]) | (w_data_q[NUM_EVT-1:0] & bmask[NUM_EVT-1:0]);
   end

   // Read data is built from the current register values, so a same-cycle commit is not visible.
   always_comb begin
      r_dec   = decode(axi.axi_araddr[31:2]);
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (r_dec.kind)
         K_CTRL: begin
            for (int k = 0; k < NUM_CTRL; k++)
               if (r_dec.idx == k)
                  rd_data = ctrl_q[k] & ~PULSE_MASK[32*k +: 32];
         end
         K_STAT: begin
            for (int k = 0; k < NUM_STAT; k++)
               if (r_dec.idx == k)
                  rd_data = stat_in[32*k +: 32];
         end
         K_PEND:  rd_data[NUM_EVT-1:0] = pend_q;
         K_EN:    rd_data[NUM_EVT-1:0] = en_q;
         K_ID:    rd_data = BLOCK_ID;
         K_SEG:   rd_resp = RESP_DECERR;
         default: rd_resp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge axilite_clk) begin
      if (axilite_rst) begin
         aw_full   <= 1'b0;
         aw_addr_q <= '0;
         w_full    <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         for (int k = 0; k < NUM_CTRL; k++)
            ctrl_q[k] <= CTRL_RESET[32*k +: 32];
         pulse_q   <= '0;
         pend_q    <= '0;
         en_q      <= '0;
         irq_q     <= 1'b0;
      end else begin
         if (axi.axi_awvalid && !aw_full) begin
            aw_full   <= 1'b1;
            aw_addr_q <= axi.axi_awaddr[31:2];
         end else if (commit) begin
            aw_full <= 1'b0;
         end

         if (axi.axi_wvalid && !w_full) begin
            w_full   <= 1'b1;
            w_data_q <= axi.axi_wdata;
            w_strb_q <= axi.axi_wstrb;
         end else if (commit) begin
            w_full <= 1'b0;
         end

         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
         end else if (axi.axi_bready) begin
            bvalid_q <= 1'b0;
         end

         if (axi.axi_arvalid && !rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
         end else if (axi.axi_rready) begin
            rvalid_q <= 1'b0;
         end

         for (int k = 0; k < NUM_CTRL; k++)
            ctrl_q[k] <= ctrl_d[k];
         pulse_q <= pulse_d;
         pend_q  <= pend_d;
         en_q    <= en_d;
         irq_q   <= |(pend_q & en_q);
      end
   end

   assign axi.axi_awready = ~aw_full;
   assign axi.axi_wready  = ~w_full;
   assign axi.axi_bvalid  = bvalid_q;
   assign axi.axi_bresp   = bresp_q;
   assign axi.axi_arready = ~rvalid_q;
   assign axi.axi_rvalid  = rvalid_q;
   assign axi.axi_rdata   = rdata_q;
   assign axi.axi_rresp   = rresp_q;

   always_comb begin
      ctrl_regs = '0;
      for (int k = 0; k < NUM_CTRL; k++)
         ctrl_regs[32*k +: 32] = ctrl_q[k];
   end

   assign ctrl_wr_pulse = pulse_q;
   assign event_pending = pend_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Bench for axil_reg_bank: a vector table of write/readback pairs plus hand-built sequences
// for holder timing, pulse bits, events, same-cycle read/commit and mid-transaction reset.
module tb_axil_reg_bank;

   localparam logic [1:0]   OK  = 2'b00;
   localparam logic [1:0]   SLV = 2'b10;
   localparam logic [1:0]   DEC = 2'b11;
   localparam logic [255:0] CRST  = {160'h0, 32'h0000_CAFE, 64'h0};
   localparam logic [255:0] PMASK = 256'h1;

   logic         clk;
   logic         rst;
   logic [255:0] ctrl_regs;
   logic [7:0]   ctrl_wr_pulse;
   logic [127:0] stat_in;
   logic [7:0]   event_in;
   logic [7:0]   event_pending;
   logic         irq;

   int n_checks;
   int n_errors;
   int ctrl0_hi;

   logic [33:0] exp_q[$];
   logic [1:0]  bexp_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      logic [31:0] rdata;
      logic [1:0]  rresp;
   } vec_t;

   vec_t vecs[14];

   axil_reg_bank_if axi();

   axil_reg_bank #(
      .ADDR_SEGMENT(16'h0000),
      .NUM_CTRL(8),
      .NUM_STAT(4),
      .NUM_EVT(8),
      .PULSE_MASK(PMASK),
      .CTRL_RESET(CRST),
      .BLOCK_ID(32'h5246_0002)
   ) dut (
      .axilite_clk(clk),
      .axilite_rst(rst),
      .axi(axi),
      .ctrl_regs(ctrl_regs),
      .ctrl_wr_pulse(ctrl_wr_pulse),
      .stat_in(stat_in),
      .event_in(event_in),
      .event_pending(event_pending),
      .irq(irq)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: responses are compared on the cycle their handshake completes.
   always @(negedge clk) begin
      if (!rst) begin
         if (axi.axi_rvalid && axi.axi_rready) begin
            if (exp_q.size() == 0) chk("r_unexpected", axi.axi_rvalid, 0);
            else begin
               logic [33:0] e;
               e = exp_q.pop_front();
               chk("rresp", axi.axi_rresp, e[33:32]);
               chk("rdata", axi.axi_rdata, e[31:0]);
            end
         end
         if (axi.axi_bvalid && axi.axi_bready) begin
            if (bexp_q.size() == 0) chk("b_unexpected", axi.axi_bvalid, 0);
            else chk("bresp", axi.axi_bresp, bexp_q.pop_front());
         end
         if (ctrl_regs[0]) ctrl0_hi++;
      end
   end

   // Driver tasks
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
      int   n;
      logic aw_hs, w_hs;
      bexp_q.push_back(exp_resp);
      axi.axi_awaddr  = addr;
      axi.axi_wdata   = data;
      axi.axi_wstrb   = strb;
      axi.axi_awvalid = 1'b1;
      axi.axi_wvalid  = 1'b1;
      axi.axi_bready  = 1'b1;
      n = 0;
      while ((axi.axi_awvalid || axi.axi_wvalid) && n < 20) begin
         aw_hs = axi.axi_awvalid & axi.axi_awready;
         w_hs  = axi.axi_wvalid & axi.axi_wready;
         tick();
         if (aw_hs) axi.axi_awvalid = 1'b0;
         if (w_hs)  axi.axi_wvalid  = 1'b0;
         n++;
      end
      if (axi.axi_awvalid || axi.axi_wvalid) begin
         chk("aw_w_accept_timeout", {axi.axi_awvalid, axi.axi_wvalid}, 2'b00);
         axi.axi_awvalid = 1'b0;
         axi.axi_wvalid  = 1'b0;
      end
      n = 0;
      while (!axi.axi_bvalid && n < 20) begin
         tick();
         n++;
      end
      chk("bvalid_seen", axi.axi_bvalid, 1);
      tick();
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
      int   n;
      logic hs;
      exp_q.push_back({exp_resp, exp_data});
      axi.axi_araddr  = addr;
      axi.axi_arvalid = 1'b1;
      axi.axi_rready  = 1'b1;
      n = 0;
      while (axi.axi_arvalid && n < 20) begin
         hs = axi.axi_arready;
         tick();
         if (hs) axi.axi_arvalid = 1'b0;
         n++;
      end
      axi.axi_arvalid = 1'b0;
      chk("rvalid_latency", axi.axi_rvalid, 1);
      n = 0;
      while (!axi.axi_rvalid && n < 20) begin
         tick();
         n++;
      end
      tick();
   endtask

   initial begin
      logic        hs;
      logic [31:0] rnd;
      n_checks = 0;
      n_errors = 0;
      ctrl0_hi = 0;
      rst = 1'b1;
      stat_in  = {32'h5354_0003, 32'h5354_0002, 32'h5354_0001, 32'h5354_0000};
      event_in = '0;
      axi.axi_awaddr = '0; axi.axi_awvalid = 1'b0;
      axi.axi_wdata = '0; axi.axi_wstrb = '0; axi.axi_wvalid = 1'b0;
      axi.axi_bready = 1'b1;
      axi.axi_araddr = '0; axi.axi_arvalid = 1'b0; axi.axi_rready = 1'b1;

      vecs[0]  = '{32'h0000_0008, 32'h1111_2222, 4'hF, OK,  32'h1111_2222, OK};
      vecs[1]  = '{32'h0000_0008, 32'hAABB_CCDD, 4'h8, OK,  32'hAA11_2222, OK};
      vecs[2]  = '{32'h0000_001C, 32'hDEAD_BEEF, 4'hF, OK,  32'hDEAD_BEEF, OK};
      vecs[3]  = '{32'h0000_0020, 32'h1234_5678, 4'hF, SLV, 32'h0,         SLV};
      vecs[4]  = '{32'h0000_0404, 32'hFFFF_FFFF, 4'hF, SLV, 32'h5354_0001, OK};
      vecs[5]  = '{32'h0000_0410, 32'h0000_0001, 4'hF, SLV, 32'h0,         SLV};
      vecs[6]  = '{32'h0000_0804, 32'hFFFF_FF04, 4'hF, OK,  32'h0000_0004, OK};
      vecs[7]  = '{32'h0000_0800, 32'hFFFF_FF00, 4'hF, OK,  32'h0,         OK};
      vecs[8]  = '{32'h0000_0FFC, 32'h0,         4'hF, SLV, 32'h5246_0002, OK};
      vecs[9]  = '{32'h0001_0000, 32'h8765_4321, 4'hF, DEC, 32'h0,         DEC};
      vecs[10] = '{32'h0000_0700, 32'h0000_0001, 4'hF, SLV, 32'h0,         SLV};
      vecs[11] = '{32'h0000_080C, 32'h0000_0001, 4'hF, SLV, 32'h0,         SLV};
      vecs[12] = '{32'h0000_0C00, 32'h0000_0001, 4'hF, SLV, 32'h0,         SLV};
      vecs[13] = '{32'h0000_000A, 32'h0000_0001, 4'h1, OK,  32'hAA11_2201, OK};

      // Reset state
      tick(); tick(); tick();
      chk("rst_ctrl_regs", ctrl_regs, CRST);
      chk("rst_awready", axi.axi_awready, 1);
      chk("rst_wready", axi.axi_wready, 1);
      chk("rst_arready", axi.axi_arready, 1);
      chk("rst_bvalid", axi.axi_bvalid, 0);
      chk("rst_rvalid", axi.axi_rvalid, 0);
      chk("rst_rdata", axi.axi_rdata, 0);
      chk("rst_pulse", ctrl_wr_pulse, 0);
      chk("rst_pending", event_pending, 0);
      chk("rst_irq", irq, 0);
      rst = 1'b0;
      tick();
      do_read(32'h0000_0FFC, 32'h5246_0002, OK);

      // W three cycles ahead of AW, response held while bready is low
      bexp_q.push_back(OK);
      axi.axi_bready = 1'b0;
      axi.axi_wdata  = 32'hA5A5_1234;
      axi.axi_wstrb  = 4'b0011;
      axi.axi_wvalid = 1'b1;
      hs = axi.axi_wready;
      tick();
      axi.axi_wvalid = 1'b0;
      chk("early_w_accept", hs, 1);
      chk("wready_when_full", axi.axi_wready, 0);
      tick(); tick();
      axi.axi_awaddr  = 32'h0000_0004;
      axi.axi_awvalid = 1'b1;
      hs = axi.axi_awready;
      tick();
      axi.axi_awvalid = 1'b0;
      chk("late_aw_accept", hs, 1);
      chk("awready_when_full", axi.axi_awready, 0);
      chk("bvalid_before_commit", axi.axi_bvalid, 0);
      chk("pulse_before_commit", ctrl_wr_pulse, 0);
      tick();
      chk("ctrl1_strobed", ctrl_regs[63:32], 32'h0000_1234);
      chk("ctrl1_wr_pulse", ctrl_wr_pulse, 8'h02);
      chk("bvalid_after_commit", axi.axi_bvalid, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bvalid_held", axi.axi_bvalid, 1);
         chk("wr_pulse_one_cycle", ctrl_wr_pulse, 0);
      end
      axi.axi_bready = 1'b1;
      tick();
      chk("bvalid_released", axi.axi_bvalid, 0);

      // Table of write / readback pairs
      for (int i = 0; i < 14; i++) begin
         do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].bresp);
         do_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp);
      end
      chk("ctrl0_untouched_by_decerr", ctrl_regs[31:0], 32'h0);
      chk("ctrl2_final", ctrl_regs[95:64], 32'hAA11_2201);
      chk("ctrl7_final", ctrl_regs[255:224], 32'hDEAD_BEEF);
      chk("ctrl1_kept", ctrl_regs[63:32], 32'h0000_1234);

      // Self-clearing bit 0 of CTRL[0]
      ctrl0_hi = 0;
      do_write(32'h0000_0000, 32'h0000_0101, 4'b0011, OK);
      tick(); tick();
      chk("pulse_bit_cycles", ctrl0_hi, 1);
      chk("pulse_bit_cleared", ctrl_regs[31:0], 32'h0000_0100);
      do_read(32'h0000_0000, 32'h0000_0100, OK);

      // Live status sampled at AR acceptance
      rnd = $urandom_range(32'h7FFF_FFFF, 0);
      stat_in[127:96] = rnd;
      do_read(32'h0000_040C, rnd, OK);

      // Events: set, irq latency, set-wins-over-clear, plain clear
      event_in = 8'h04;
      tick();
      event_in = 8'h00;
      chk("evt_pending_set", event_pending, 8'h04);
      chk("irq_not_yet", irq, 0);
      tick();
      chk("irq_asserted", irq, 1);
      do_read(32'h0000_0800, 32'h0000_0004, OK);
      bexp_q.push_back(OK);
      axi.axi_awaddr = 32'h0000_0800; axi.axi_wdata = 32'h4; axi.axi_wstrb = 4'hF;
      axi.axi_awvalid = 1'b1; axi.axi_wvalid = 1'b1;
      tick();
      axi.axi_awvalid = 1'b0; axi.axi_wvalid = 1'b0;
      event_in = 8'h04;
      tick();
      event_in = 8'h00;
      chk("set_wins_over_clear", event_pending, 8'h04);
      chk("w1c_bvalid", axi.axi_bvalid, 1);
      tick();
      chk("irq_still_high", irq, 1);
      do_write(32'h0000_0800, 32'h0000_0004, 4'hF, OK);
      chk("evt_cleared", event_pending, 8'h00);
      chk("irq_cleared", irq, 0);
      event_in = 8'h80;
      tick();
      event_in = 8'h00;
      tick(); tick();
      chk("masked_evt_pending", event_pending, 8'h80);
      chk("masked_evt_no_irq", irq, 0);
      do_write(32'h0000_0800, 32'h0000_0080, 4'h1, OK);
      chk("masked_evt_cleared", event_pending, 8'h00);

      // Read and commit hit CTRL[3] on the same edge
      bexp_q.push_back(OK);
      exp_q.push_back({OK, 32'h0});
      axi.axi_awaddr = 32'h0000_000C; axi.axi_wdata = 32'h1234_5678; axi.axi_wstrb = 4'hF;
      axi.axi_awvalid = 1'b1; axi.axi_wvalid = 1'b1;
      tick();
      axi.axi_awvalid = 1'b0; axi.axi_wvalid = 1'b0;
      axi.axi_araddr = 32'h0000_000C; axi.axi_arvalid = 1'b1;
      hs = axi.axi_arready;
      tick();
      axi.axi_arvalid = 1'b0;
      chk("same_cycle_ar_accept", hs, 1);
      chk("same_cycle_rvalid", axi.axi_rvalid, 1);
      chk("same_cycle_bvalid", axi.axi_bvalid, 1);
      tick();
      do_read(32'h0000_000C, 32'h1234_5678, OK);

      // Reset with a response pending and the W holder full
      axi.axi_bready = 1'b0;
      axi.axi_awaddr = 32'h0000_0010; axi.axi_wdata = 32'h7777_7777; axi.axi_wstrb = 4'hF;
      axi.axi_awvalid = 1'b1; axi.axi_wvalid = 1'b1;
      tick();
      axi.axi_awvalid = 1'b0; axi.axi_wvalid = 1'b0;
      tick();
      chk("pre_rst_bvalid", axi.axi_bvalid, 1);
      axi.axi_wdata = 32'h9999_9999; axi.axi_wvalid = 1'b1;
      hs = axi.axi_wready;
      tick();
      axi.axi_wvalid = 1'b0;
      chk("pre_rst_w_accept", hs, 1);
      chk("pre_rst_wready", axi.axi_wready, 0);
      rst = 1'b1;
      tick();
      chk("mid_rst_bvalid", axi.axi_bvalid, 0);
      chk("mid_rst_wready", axi.axi_wready, 1);
      chk("mid_rst_awready", axi.axi_awready, 1);
      chk("mid_rst_ctrl_regs", ctrl_regs, CRST);
      chk("mid_rst_pending", event_pending, 0);
      rst = 1'b0;
      exp_q.delete();
      bexp_q.delete();
      axi.axi_bready = 1'b1;
      tick();
      do_write(32'h0000_0014, 32'h0BAD_F00D, 4'hF, OK);
      do_read(32'h0000_0014, 32'h0BAD_F00D, OK);
      do_read(32'h0000_0010, 32'h0, OK);

      tick(); tick();
      chk("r_queue_drained", exp_q.size(), 0);
      chk("b_queue_drained", bexp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
- Native AXI-Lite slave register bank, parametrised in control register count, status count and event count; no APB bridge stage.
- Provides RW control words with optional self-clearing pulse bits.
- Provides live read-only status words, plus sticky event flags with write-1-to-clear and a level interrupt.
- Sits between the PS AXI-Lite interconnect and the DAC/ADC/GTY control logic.

Parameters:
ADDR_SEGMENT, 16'h0000, required value of addr[31:16]; any other value is a decode miss
NUM_CTRL, 8, number of 32-bit RW control registers (1..64)
NUM_STAT, 4, number of 32-bit RO status words (1..64)
NUM_EVT, 8, number of sticky event flags (1..32)
PULSE_MASK, {NUM_CTRL*32{1'b0}}, per-bit: 1 = bit self-clears one cycle after being written 1
CTRL_RESET, {NUM_CTRL*32{1'b0}}, reset value of the control registers
BLOCK_ID, 32'h5246_0002, constant returned at the ID register

Ports:
axilite_clk  in  1  clock for all logic
axilite_rst  in  1  synchronous reset, active-high
axi_awaddr  in  32  write address
axi_awvalid/axi_awready  in/out  1  AW handshake
axi_wdata  in  32  write data
axi_wstrb  in  4  byte strobes
axi_wvalid/axi_wready  in/out  1  W handshake
axi_bresp  out  2  write response
axi_bvalid/axi_bready  out/in  1  B handshake
axi_araddr  in  32  read address
axi_arvalid/axi_arready  in/out  1  AR handshake
axi_rdata  out  32  read data
axi_rresp  out  2  read response
axi_rvalid/axi_rready  out/in  1  R handshake
ctrl_regs  out  NUM_CTRL*32  control words; register k occupies bits [32k+31:32k]
ctrl_wr_pulse  out  NUM_CTRL  one-cycle strobe per register on a committed write
stat_in  in  NUM_STAT*32  live status words
event_in  in  NUM_EVT  event set pulses (level sampled every cycle)
event_pending  out  NUM_EVT  sticky event flags
irq  out  1  |(event_pending & event_enable)

Behaviour:
- Address map, offset = addr[15:0], word aligned (addr[1:0] ignored):
  - 0x000+4k: CTRL[k], RW
  - 0x400+4k: STAT[k], RO
  - 0x800: EVT_PENDING, W1C
  - 0x804: EVT_ENABLE, RW, reset 0
  - 0xFFC: BLOCK_ID, RO
- Decode errors:
  - Segment mismatch -> resp DECERR (2'b11).
  - In-segment unmapped offset, or write to an RO register -> SLVERR (2'b10).
  - On any error: no state change; read data = 32'h0.
- Reset values: awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, ctrl_regs=CTRL_RESET, ctrl_wr_pulse=0, event_pending=0, irq=0.
- Write path:
  - AW and W are captured independently into one-deep holding registers.
  - awready = AW holder empty; wready = W holder empty.
  - Commit cycle C = both holders full and bvalid=0.
  - At C: apply the write using wstrb per byte; both holders empty.
  - Cycle C+1: bvalid=1 and register outputs show the new value.
  - bvalid holds until bready; a new commit is blocked while bvalid=1.
  - AW and W arriving on the same cycle as a commit is legal. Max throughput is one write per 2 cycles with bready tied high.
- PULSE_MASK bits: a written 1 appears for exactly one cycle (C+1), then clears; these bits always read 0.
- ctrl_wr_pulse[k]: high at C+1 for one cycle when CTRL[k] is written (any strobe). Not asserted on error.
- Read path:
  - arready = !rvalid.
  - AR accepted at cycle A: rdata/rresp are registered and rvalid=1 at A+1, held stable until rready.
  - A read and a commit to the same register in the same cycle: the read returns the pre-write value.
- Events, per cycle: pending_next = (pending & ~clr) | event_in, where clr = EVT_PENDING write data masked by wstrb. Set wins over simultaneous clear.
  - Bits at or above NUM_EVT read 0, ignore writes, and do not produce an error.
- irq is registered; it is high one cycle after pending&enable becomes nonzero.
- stat_in is sampled at AR acceptance; there is no synchroniser (inputs must already be in this clock domain).
- Reset asserted mid-transaction:
  - All holders and pending responses are dropped next cycle.
  - Outputs return to reset values.
  - The master is responsible for not expecting an outstanding response.

Test Plan:
- Reset -> ctrl_regs=CTRL_RESET, awready=wready=arready=1, bvalid=rvalid=0; read 0xFFC -> rdata=32'h52460002, rresp=0, rvalid one cycle after AR.
- W sent 3 cycles before AW to 0x004, data 32'hA5A5_1234, wstrb=4'b0011 (prior 0) -> CTRL[1]=32'h0000_1234, ctrl_wr_pulse[1] single cycle, bvalid held 5 cycles with bready low, bresp=0.
- PULSE_MASK bit 0 of CTRL[0] set, write 1 -> ctrl_regs[0] high exactly one cycle; readback of 0x000 bit 0 = 0.
- event_in[2] pulse, EVT_ENABLE=4 -> event_pending=4, irq=1 next cycle; W1C 0x800 data 4 in the same cycle as another event_in[2] -> pending stays 4; later clear without event -> pending 0, irq 0.
- Read addr 32'h0001_0000 -> rresp=DECERR, rdata 0; write to 0x400 -> bresp=SLVERR, STAT unaffected; read 0x700 -> SLVERR.
- Assert axilite_rst while bvalid=1 and the W holder is full -> next cycle bvalid=0, wready=1, ctrl_regs=CTRL_RESET.
